// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU and the blocks that issue work to it:
// operand/opcode widths, opcode encodings and the arbiter FSM states.
package alu_ctrl_pkg;

    localparam int OPND_W = 4;
    localparam int OP_W   = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_RESP    = 2'b11
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-requester grant logic. Produces a one-hot grant from the request
// valids and the index of the requester granted last time. With
// FIXED_PRIO set, requester 0 always wins when it is requesting.
module rr_arb2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] i_valid,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    // Pick a single winner; a tie goes to the requester not granted last.
    always_comb begin
        o_grant = 2'b00;
        if (FIXED_PRIO) begin
            if (i_valid[0]) begin
                o_grant = 2'b01;
            end else if (i_valid[1]) begin
                o_grant = 2'b10;
            end
        end else begin
            case (i_valid)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters. One operation is in
// flight at a time: IDLE grants and loads operands, ISSUE lets the ALU
// sample them, CAPTURE latches the ALU outputs into the response
// registers, RESP holds the response until the consumer takes it.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OPND_W-1:0] req0_a,
    input  logic [OPND_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OPND_W-1:0] req1_a,
    input  logic [OPND_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [OPND_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [OPND_W-1:0] rsp_result,
    output logic              rsp_carry,
    output logic              rsp_zero,
    output logic              busy
);

    arb_state_e        r_state;
    arb_state_e        w_next_state;
    logic [1:0]        w_grant;
    logic              w_accept;

    logic              r_last;
    logic              r_gnt_id;
    logic [OPND_W-1:0] r_alu_a;
    logic [OPND_W-1:0] r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic              r_rsp_valid;
    logic              r_rsp_id;
    logic [OPND_W-1:0] r_rsp_result;
    logic              r_rsp_carry;
    logic              r_rsp_zero;

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .i_valid (({req1_valid, req0_valid})),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    // State register; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and grant handshake; ready is only offered in IDLE and
    // is held low while reset is asserted.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rst_n && (w_grant != 2'b00)) begin
                    w_accept     = 1'b1;
                    req0_ready   = w_grant[0];
                    req1_ready   = w_grant[1];
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE:   w_next_state = ST_CAPTURE;
            ST_CAPTURE: w_next_state = ST_RESP;
            ST_RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Operand/opcode registers and grant bookkeeping, loaded only on a
    // grant so the ALU inputs stay quiet between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= OP_ADD;
            r_gnt_id <= 1'b0;
            r_last   <= 1'b1;
        end else if (w_accept) begin
            r_alu_a  <= w_grant[1] ? req1_a  : req0_a;
            r_alu_b  <= w_grant[1] ? req1_b  : req0_b;
            r_alu_op <= w_grant[1] ? req1_op : req0_op;
            r_gnt_id <= w_grant[1];
            r_last   <= w_grant[1];
        end
    end

    // Response registers: latch ALU outputs untouched in CAPTURE, hold
    // them through RESP, drop valid on the consumer handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_zero   <= 1'b0;
        end else if (r_state == ST_CAPTURE) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= r_gnt_id;
            r_rsp_result <= alu_result;
            r_rsp_carry  <= alu_carry;
            r_rsp_zero   <= alu_zero;
        end else if ((r_state == ST_RESP) && r_rsp_valid && rsp_ready) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_zero   = r_rsp_zero;
    assign busy       = (r_state != ST_IDLE);

endmodule
